send_arbiter: RTL and testbench

//  Shares the single send path (pixel + pivot/size/median-pos/second-median FIFO writer) among
//  N_REQ partition buffers of the median accelerator. Round-robin picks a requester and drives

---
 rtl/send_arbiter.sv | 133 +++++++++++++
 tb/tb_send_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/send_arbiter.sv
// send_arbiter: round-robin owner of the single send path shared by the partition buffers.
// A winner is latched in idle; real bursts go through a send_req/sending handshake, while
// zero-size and oversize requests are retired straight away with a done pulse.
module send_arbiter #(
  parameter int N_REQ         = 2,
  parameter int BUFF_SIZE     = 32,
  parameter int BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1,
  parameter int CNT_W         = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [N_REQ-1:0]               i_req_valid,
  input  logic [N_REQ*BUFF_SIZE_BIT-1:0] i_req_size,
  output logic [N_REQ-1:0]               o_req_grant,
  output logic [N_REQ-1:0]               o_req_done,
  output logic                           o_req_err,
  output logic                           o_send_req,
  output logic [BUFF_SIZE_BIT-1:0]       o_send_buff_size,
  input  logic                           i_sending,
  output logic                           o_busy,
  output logic [CNT_W-1:0]               o_burst_cnt
);

  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic [1:0] {StIdle, StReq, StBusy, StDone} state_e;

  state_e                   r_state, w_state_d;
  logic [IDX_W-1:0]         r_rr_ptr, w_rr_ptr_d;
  logic [IDX_W-1:0]         r_idx, w_idx_d;
  logic [BUFF_SIZE_BIT-1:0] r_size, w_size_d;
  logic                     r_err, w_err_d;
  logic [N_REQ-1:0]         r_grant, w_grant_d;
  logic [CNT_W-1:0]         r_burst_cnt, w_burst_cnt_d;

  logic                     w_found;
  logic [IDX_W-1:0]         w_pick;
  logic [BUFF_SIZE_BIT-1:0] w_pick_size;
  logic                     w_pick_err;
  logic                     w_pick_zero;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && i_req_valid[(int'(r_rr_ptr) + k) % N_REQ]) begin
        w_found = 1'b1;
        w_pick  = IDX_W'((int'(r_rr_ptr) + k) % N_REQ);
      end
    end
    w_pick_size = i_req_size[int'(w_pick)*BUFF_SIZE_BIT +: BUFF_SIZE_BIT];
    w_pick_zero = (w_pick_size == '0);
    w_pick_err  = (w_pick_size > BUFF_SIZE_BIT'(BUFF_SIZE));
  end

  // Next-state and next-register logic for the burst sequencer.
  always_comb begin
    w_state_d     = r_state;
    w_rr_ptr_d    = r_rr_ptr;
    w_idx_d       = r_idx;
    w_size_d      = r_size;
    w_err_d       = r_err;
    w_grant_d     = r_grant;
    w_burst_cnt_d = r_burst_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_idx_d  = w_pick;
          w_size_d = w_pick_size;
          w_err_d  = w_pick_err;
          if (w_pick_zero || w_pick_err) begin
            // Retire without touching the send path.
            w_state_d = StDone;
          end else begin
            w_state_d = StReq;
            w_grant_d = N_REQ'(1) << w_pick;
          end
        end
      end
      StReq: begin
        if (i_sending) w_state_d = StBusy;
      end
      StBusy: begin
        if (!i_sending) begin
          w_state_d     = StDone;
          w_grant_d     = '0;
          // Only real bursts reach here, so the count excludes skips and errors.
          w_burst_cnt_d = r_burst_cnt + CNT_W'(1);
        end
      end
      StDone: begin
        w_state_d  = StIdle;
        w_err_d    = 1'b0;
        w_rr_ptr_d = (r_idx == IDX_W'(N_REQ - 1)) ? '0 : r_idx + IDX_W'(1);
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset may hit mid-burst.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_rr_ptr    <= '0;
      r_idx       <= '0;
      r_size      <= '0;
      r_err       <= 1'b0;
      r_grant     <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_d;
      r_rr_ptr    <= w_rr_ptr_d;
      r_idx       <= w_idx_d;
      r_size      <= w_size_d;
      r_err       <= w_err_d;
      r_grant     <= w_grant_d;
      r_burst_cnt <= w_burst_cnt_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    o_req_grant      = r_grant;
    o_send_req       = (r_state == StReq);
    o_busy           = (r_state != StIdle);
    o_req_done       = (r_state == StDone) ? (N_REQ'(1) << r_idx) : '0;
    o_req_err        = (r_state == StDone) && r_err;
    o_send_buff_size = (|r_grant) ? r_size : '0;
    o_burst_cnt      = r_burst_cnt;
  end

endmodule

// File: tb/tb_send_arbiter.sv
// Bench for send_arbiter: directed vector table, reset and counter-wrap sequences, then
// randomized traffic against a transaction-level round-robin model.
module tb_send_arbiter;

  localparam int N   = 2;
  localparam int BS  = 32;
  localparam int BSB = 6;
  localparam int CW  = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*BSB-1:0] req_size;
  logic           sending;
  logic [N-1:0]   grant, done;
  logic           err, send_req, busy;
  logic [BSB-1:0] sbs;
  logic [CW-1:0]  cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  send_arbiter #(
    .N_REQ        (N),
    .BUFF_SIZE    (BS),
    .BUFF_SIZE_BIT(BSB),
    .CNT_W        (CW)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_req_valid     (req_valid),
    .i_req_size      (req_size),
    .o_req_grant     (grant),
    .o_req_done      (done),
    .o_req_err       (err),
    .o_send_req      (send_req),
    .o_send_buff_size(sbs),
    .i_sending       (sending),
    .o_busy          (busy),
    .o_burst_cnt     (cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Spec rule: first pending requester at or after ptr, wrapping.
  function automatic int rr_pick(input logic [N-1:0] p, input int ptr);
    for (int k = 0; k < N; k++) if (p[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  typedef struct {
    logic [N-1:0]   v;
    logic [BSB-1:0] s0, s1;
    logic           snd;
    logic [N-1:0]   g, d;
    logic           e, sr, b;
    logic [BSB-1:0] sz;
    logic [CW-1:0]  c;
  } vec_t;

  vec_t tbl[25];

  // One real burst from requester 0; valid is dropped while busy.
  task automatic burst0(input logic [BSB-1:0] sz);
    int t;
    req_size[BSB-1:0] = sz;
    req_valid = 2'b01;
    t = 0;
    do begin @(posedge clk); #1; t++; end while (!send_req && t < 20);
    if (!send_req) timeout_fail("burst0_send_req");
    sending = 1'b1;
    @(posedge clk); #1;
    sending = 1'b0;
    req_valid = 2'b00;
    t = 0;
    while (done == '0 && t < 20) begin @(posedge clk); #1; t++; end
    if (done == '0) timeout_fail("burst0_done");
    @(posedge clk); #1;
  endtask

  initial begin
    logic [N-1:0]   pending, vdrv;
    logic [BSB-1:0] msize [N];
    int             ptr, mcnt, phase, rwait, rlen, idle, exp_i;
    logic           saw_sr, prev_sr;

    // {valid, size0, size1, sending} -> {grant, done, err, send_req, busy, size, cnt}
    tbl[0]  = '{2'b01,  6'd5, 6'd0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b1,  6'd5, 4'd0};
    tbl[1]  = '{2'b01,  6'd5, 6'd0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b1,  6'd5, 4'd0};
    tbl[2]  = '{2'b01,  6'd5, 6'd0, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1,  6'd5, 4'd0};
    tbl[3]  = '{2'b01,  6'd5, 6'd0, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1,  6'd5, 4'd0};
    tbl[4]  = '{2'b00,  6'd5, 6'd0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1,  6'd0, 4'd1};
    tbl[5]  = '{2'b00,  6'd5, 6'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0,  6'd0, 4'd1};
    tbl[6]  = '{2'b01,  6'd0, 6'd0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1,  6'd0, 4'd1};
    tbl[7]  = '{2'b01, 6'd33, 6'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0,  6'd0, 4'd1};
    tbl[8]  = '{2'b01, 6'd33, 6'd0, 1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 1'b1,  6'd0, 4'd1};
    tbl[9]  = '{2'b00, 6'd33, 6'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0,  6'd0, 4'd1};
    tbl[10] = '{2'b01, 6'd32, 6'd0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b1, 6'd32, 4'd1};
    tbl[11] = '{2'b01, 6'd32, 6'd0, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 6'd32, 4'd1};
    tbl[12] = '{2'b01,  6'd7, 6'd0, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 6'd32, 4'd1};
    tbl[13] = '{2'b00,  6'd7, 6'd0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1,  6'd0, 4'd2};
    tbl[14] = '{2'b00,  6'd7, 6'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0,  6'd0, 4'd2};
    tbl[15] = '{2'b11,  6'd4, 6'd4, 1'b0, 2'b10, 2'b00, 1'b0, 1'b1, 1'b1,  6'd4, 4'd2};
    tbl[16] = '{2'b11,  6'd4, 6'd4, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1,  6'd4, 4'd2};
    tbl[17] = '{2'b11,  6'd4, 6'd4, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1,  6'd0, 4'd3};
    tbl[18] = '{2'b11,  6'd4, 6'd4, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0,  6'd0, 4'd3};
    tbl[19] = '{2'b11,  6'd4, 6'd4, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b1,  6'd4, 4'd3};
    tbl[20] = '{2'b11,  6'd4, 6'd4, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1,  6'd4, 4'd3};
    tbl[21] = '{2'b11,  6'd4, 6'd4, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1,  6'd0, 4'd4};
    tbl[22] = '{2'b11,  6'd4, 6'd4, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0,  6'd0, 4'd4};
    tbl[23] = '{2'b11,  6'd4, 6'd4, 1'b0, 2'b10, 2'b00, 1'b0, 1'b1, 1'b1,  6'd4, 4'd4};
    tbl[24] = '{2'b11,  6'd4, 6'd4, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1,  6'd4, 4'd4};

    rst = 1'b1;
    req_valid = '0;
    req_size = '0;
    sending = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {grant, done, err, send_req, busy, sbs, cnt}, '0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      req_valid = tbl[i].v;
      req_size  = {tbl[i].s1, tbl[i].s0};
      sending   = tbl[i].snd;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), {grant, done, err, send_req, busy, sbs, cnt},
            {tbl[i].g, tbl[i].d, tbl[i].e, tbl[i].sr, tbl[i].b, tbl[i].sz, tbl[i].c});
    end

    // Asynchronous reset mid-burst while requester 1 owns the path (rr_ptr=1).
    #3 rst = 1'b1;
    #1;
    check("async_reset", {grant, done, err, send_req, busy, sbs, cnt}, '0);
    sending = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 2'b11;
    req_size = {6'd4, 6'd4};
    @(posedge clk); #1;
    check("ptr_after_reset", {grant, send_req}, {2'b01, 1'b1});
    sending = 1'b1;
    @(posedge clk); #1;
    sending = 1'b0;
    req_valid = 2'b00;
    @(posedge clk); #1;
    check("cnt_after_reset", {done, cnt}, {2'b01, 4'd1});
    @(posedge clk); #1;

    // Drive the counter to its maximum, then one more burst wraps it.
    for (int i = 0; i < 14; i++) burst0(6'd1);
    check("cnt_max", cnt, 4'd15);
    burst0(6'd1);
    check("cnt_wrap", cnt, 4'd0);

    // Randomized traffic against the transaction-level model.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ptr = 0; mcnt = 0; phase = 0; rwait = 0; rlen = 0; idle = 0;
    saw_sr = 1'b0; prev_sr = 1'b0;
    pending = '0;
    for (int j = 0; j < N; j++) begin
      int r;
      r = $urandom_range(0, 9);
      msize[j] = (r == 0) ? 6'd0 : (r == 1) ? BSB'($urandom_range(33, 63)) :
                 (r == 2) ? 6'd32 : BSB'($urandom_range(1, 31));
      pending[j] = ($urandom_range(0, 3) != 0);
      req_size[j*BSB +: BSB] = msize[j];
    end
    if (pending == '0) pending[0] = 1'b1;
    vdrv = pending;
    req_valid = vdrv;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk); #1;
      exp_i = rr_pick(pending, ptr);
      check("grant_onehot", $onehot0(grant), 1'b1);
      check("sreq_vs_sending", send_req & sending, 1'b0);
      if (send_req) begin
        saw_sr = 1'b1;
        check("sreq_size", sbs, msize[exp_i]);
        if (!prev_sr) check("grant_pick", grant, N'(1) << exp_i);
      end
      prev_sr = send_req;

      if (done != '0) begin
        logic real_b;
        idle = 0;
        real_b = (msize[exp_i] != 0) && (msize[exp_i] <= BS);
        check("done_idx", done, N'(1) << exp_i);
        check("done_err", err, msize[exp_i] > BS);
        if (real_b) mcnt = (mcnt + 1) % (1 << CW);
        check("burst_cnt", cnt, mcnt);
        check("real_sent", saw_sr, real_b);
        saw_sr = 1'b0;
        pending[exp_i] = 1'b0;
        vdrv[exp_i] = 1'b0;
        ptr = (exp_i + 1) % N;
        for (int j = 0; j < N; j++) begin
          if (!pending[j] && $urandom_range(0, 1) == 1) pending[j] = 1'b1;
        end
        if (pending == '0) pending[exp_i] = 1'b1;
        for (int j = 0; j < N; j++) begin
          if (pending[j] && !vdrv[j]) begin
            int r;
            r = $urandom_range(0, 9);
            msize[j] = (r == 0) ? 6'd0 : (r == 1) ? BSB'($urandom_range(33, 63)) :
                       (r == 2) ? 6'd32 : BSB'($urandom_range(1, 31));
            req_size[j*BSB +: BSB] = msize[j];
            vdrv[j] = 1'b1;
          end
        end
      end else begin
        idle++;
        if (idle > 200) begin
          timeout_fail("random_done");
          break;
        end
      end

      // Once granted, a requester may drop valid or wiggle its size; neither may matter.
      if (grant != '0 && exp_i >= 0 && $urandom_range(0, 3) == 0) begin
        vdrv[exp_i] = 1'b0;
        req_size[exp_i*BSB +: BSB] = BSB'($urandom);
      end
      req_valid = vdrv;

      // Send-path responder.
      case (phase)
        0: if (send_req) begin
          rwait = $urandom_range(0, 3);
          if (rwait == 0) begin sending = 1'b1; rlen = $urandom_range(1, 5); phase = 2; end
          else phase = 1;
        end
        1: begin
          rwait--;
          if (rwait == 0) begin sending = 1'b1; rlen = $urandom_range(1, 5); phase = 2; end
        end
        default: begin
          rlen--;
          if (rlen == 0) begin sending = 1'b0; phase = 0; end
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
